// File: rtl/mem_align_bridge.sv
// CPU load/store to aligned memory-beat bridge: splits unaligned byte/half/word
// accesses into MEM_W-wide beats, reassembles read data and flags window faults.
module mem_align_bridge #(
    parameter int          MEM_W     = 16,
    parameter logic [31:0] WIN_BASE  = 32'h0001_0000,
    parameter logic [31:0] WIN_LIMIT = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               req_rw,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_size,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic               mem_req,
    output logic               mem_rw,
    output logic [31:0]        mem_addr,
    output logic [MEM_W/8-1:0] mem_be,
    output logic [MEM_W-1:0]   mem_wdata,
    input  logic [MEM_W-1:0]   mem_rdata,
    input  logic               mem_ack
);

    localparam int L  = MEM_W / 8;
    localparam int LW = $clog2(L);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic        r_rw;

    logic [31:0]      w_src_addr;
    logic [31:0]      w_src_wdata;
    logic [1:0]       w_src_size;
    logic [1:0]       w_src_idx;
    logic [31:0]      w_beat_addr;
    logic [L-1:0]     w_beat_be;
    logic [MEM_W-1:0] w_beat_wdata;
    logic [31:0]      w_rdata_next;
    logic [32:0]      w_end;
    logic             w_fault;
    logic [1:0]       w_last_in;

    function automatic int size_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Position within the CPU access of the byte carried by lane j of beat idx.
    function automatic int lane_pos(input logic [LW-1:0] off, input logic [1:0] idx, input int j);
        return int'(idx) * L + j - int'(off);
    endfunction

    // In IDLE the first beat is built from the live request; in BEAT the
    // following beat is built from the latched request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_src_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
        w_src_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;
        w_src_size   = (r_state == S_IDLE) ? req_size  : r_size;
        w_src_idx    = (r_state == S_IDLE) ? 2'd0      : r_idx + 2'd1;
        w_beat_addr  = {w_src_addr[31:LW], {LW{1'b0}}} + 32'(w_src_idx) * 32'(L);
        w_beat_be    = '0;
        w_beat_wdata = '0;
        for (int j = 0; j < L; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_pos(w_src_addr[LW-1:0], w_src_idx, j) == k && k < size_bytes(w_src_size)) begin
                    w_beat_be[j]           = 1'b1;
                    w_beat_wdata[8*j +: 8] = w_src_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rdata_next = rsp_rdata;
        for (int j = 0; j < L; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_pos(r_addr[LW-1:0], r_idx, j) == k && k < size_bytes(r_size)) begin
                    w_rdata_next[8*k +: 8] = mem_rdata[8*j +: 8];
                end
            end
        end
    end

    // Window end is computed in 33 bits so an access straddling 2^32 cannot wrap into range.
    always_comb begin
        w_end     = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
        w_fault   = (req_size == 2'd3) || (req_addr < WIN_BASE) || (w_end >= {1'b0, WIN_LIMIT});
        w_last_in = 2'((int'(req_addr[LW-1:0]) + size_bytes(req_size) - 1) / L);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_idx     <= '0;
            r_last    <= '0;
            r_rw      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_rw    <= req_rw;
                        if (w_fault) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            rsp_rdata <= '0;
                            r_idx     <= 2'd0;
                            r_last    <= w_last_in;
                            mem_req   <= 1'b1;
                            mem_rw    <= req_rw;
                            mem_addr  <= w_beat_addr;
                            mem_be    <= w_beat_be;
                            mem_wdata <= w_beat_wdata;
                            r_state   <= S_BEAT;
                        end
                    end
                end
                S_BEAT: begin
                    if (mem_req && mem_ack) begin
                        if (!r_rw) begin
                            rsp_rdata <= w_rdata_next;
                        end
                        if (r_idx == r_last) begin
                            mem_req   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            r_state   <= S_RESP;
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            mem_addr  <= w_beat_addr;
                            mem_be    <= w_beat_be;
                            mem_wdata <= w_beat_wdata;
                        end
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (!req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
